// File: rtl/spectrum_bar_renderer_pkg.sv
// spectrum_pkg: timing constants shared with the VGA timing generator, RGB444 colours,
// the peak-walk state type and small helper functions for the spectrum bar renderer.
package spectrum_pkg;

    localparam int ACTIVE_H = 640;
    localparam int ACTIVE_V = 480;

    localparam logic [11:0] RGB_GREEN = 12'h0F0;
    localparam logic [11:0] RGB_BLACK = 12'h000;
    localparam logic [11:0] RGB_RED   = 12'hF00;

    typedef enum logic [0:0] {
        WALK_IDLE = 1'b0,
        WALK_RUN  = 1'b1
    } walk_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic logic [15:0] clamp_mag(input logic [15:0] mag, input logic [15:0] limit);
        if (mag > limit) begin
            return limit;
        end else begin
            return mag;
        end
    endfunction

endpackage

// File: rtl/spectrum_bar_renderer_if.sv
// Magnitude write/commit bus between the FFT side (master) and the bar renderer (slave).
interface spectrum_bar_renderer_if #(
    parameter int ADDR_W = 5,
    parameter int MAG_W  = 9
);
    logic              bin_wr_en;
    logic [ADDR_W-1:0] bin_wr_addr;
    logic [MAG_W-1:0]  bin_wr_data;
    logic              bin_commit;
    logic              bin_busy;

    modport master (output bin_wr_en, bin_wr_addr, bin_wr_data, bin_commit, input bin_busy);
    modport slave  (input bin_wr_en, bin_wr_addr, bin_wr_data, bin_commit, output bin_busy);
endinterface

// File: rtl/spectrum_bar_renderer_col_to_bar.sv
// col_to_bar: tracks bar index and within-bar offset by counting from col==0, avoiding a divider.
module col_to_bar #(
    parameter int BAR_WIDTH = 20,
    parameter int BAR_W     = 5,
    parameter int OFF_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       col,
    output logic [BAR_W-1:0] bar_idx,
    output logic [OFF_W-1:0] offset
);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BAR_WIDTH - 1);

    logic [BAR_W-1:0] bar_idx_r;
    logic [OFF_W-1:0] offset_r;

    // Counter registers: restart at col 0, wrap the offset at the end of each bar
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_idx_r <= '0;
            offset_r  <= '0;
        end else if (col == 10'd0) begin
            bar_idx_r <= '0;
            offset_r  <= '0;
        end else if (offset_r == OFF_LAST) begin
            bar_idx_r <= bar_idx_r + BAR_W'(1);
            offset_r  <= '0;
        end else begin
            offset_r  <= offset_r + OFF_W'(1);
        end
    end

    assign bar_idx = bar_idx_r;
    assign offset  = offset_r;
endmodule

// File: rtl/spectrum_bar_renderer.sv
// Spectrum bar renderer: double-buffered bar magnitudes drawn as RGB444 through a 2-cycle pipeline.
// Optional peak-hold markers are compiled in when PEAK_HOLD_EN is defined.
module spectrum_bar_renderer #(
    parameter int          NUM_BARS  = 32,
    parameter int          BAR_WIDTH = 20,
    parameter int          GAP_PX    = 2,
    parameter int          ACTIVE_H  = spectrum_pkg::ACTIVE_H,
    parameter int          ACTIVE_V  = spectrum_pkg::ACTIVE_V,
    parameter int          MAG_WIDTH = 9,
    parameter logic [11:0] BAR_COLOR = spectrum_pkg::RGB_GREEN,
    parameter logic [11:0] BG_COLOR  = spectrum_pkg::RGB_BLACK
) (
    input  logic                   clk,
    input  logic                   resetn,
    spectrum_bar_renderer_if.slave bin,
    input  logic [9:0]             row,
    input  logic [9:0]             col,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   data_enable_in,
    input  logic                   frame_pulse,
    output logic [11:0]            rgb_out,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   de_out
);
    import spectrum_pkg::*;

    localparam int BAR_W = clog2(NUM_BARS);
    localparam int OFF_W = clog2(BAR_WIDTH);
    localparam int ROW_W = 10;
    localparam logic [OFF_W-1:0] LIT_W  = OFF_W'(BAR_WIDTH - GAP_PX);
    localparam logic [ROW_W-1:0] V_L    = ROW_W'(ACTIVE_V);
    localparam logic [ROW_W-1:0] H_L    = ROW_W'(ACTIVE_H);
    localparam logic [BAR_W:0]   BARS_L = (BAR_W + 1)'(NUM_BARS);

    logic [1:0]           rst_sync_r;
    logic                 rst_n_s;
    logic [MAG_WIDTH-1:0] bank_r [0:1][0:NUM_BARS-1];
    logic                 sel_r;
    logic                 busy_r;
    logic                 wr_ok_s;
    logic [MAG_WIDTH-1:0] wr_mag_s;
    logic [BAR_W-1:0]     bar_idx_s;
    logic [OFF_W-1:0]     offset_s;
    logic [ROW_W-1:0]     row_r1;
    logic                 de_r1, hs_r1, vs_r1, h_ok_r1;
    logic [MAG_WIDTH-1:0] mag_s;
    logic [ROW_W-1:0]     thr_s;
    logic                 in_bar_s, lit_s;
    logic [11:0]          color_s;

    // Reset release synchroniser; assertion remains asynchronous
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end
    assign rst_n_s = rst_sync_r[1];

    // Write qualification and height clamp
    always_comb begin
        wr_ok_s  = bin.bin_wr_en && !busy_r && ({1'b0, bin.bin_wr_addr} < BARS_L);
        wr_mag_s = MAG_WIDTH'(clamp_mag(16'(bin.bin_wr_data), 16'(ACTIVE_V)));
    end

    // Bank storage, front-bank select and commit-pending flag
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NUM_BARS; i++) begin
                    bank_r[b][i] <= '0;
                end
            end
            sel_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            if (frame_pulse && busy_r) begin
                sel_r  <= ~sel_r;
                busy_r <= 1'b0;
            end else if (bin.bin_commit) begin
                busy_r <= 1'b1;
            end
            if (wr_ok_s) begin
                bank_r[~sel_r][bin.bin_wr_addr] <= wr_mag_s;
            end
        end
    end
    assign bin.bin_busy = busy_r;

    col_to_bar #(
        .BAR_WIDTH (BAR_WIDTH),
        .BAR_W     (BAR_W),
        .OFF_W     (OFF_W)
    ) u_col_to_bar (
        .clk     (clk),
        .rst_n   (rst_n_s),
        .col     (col),
        .bar_idx (bar_idx_s),
        .offset  (offset_s)
    );

    // Stage 1: row, visibility and syncs aligned with the bar/offset counter
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            row_r1  <= '0;
            de_r1   <= 1'b0;
            hs_r1   <= 1'b1;
            vs_r1   <= 1'b1;
            h_ok_r1 <= 1'b0;
        end else begin
            row_r1  <= row;
            de_r1   <= data_enable_in;
            hs_r1   <= hsync_in;
            vs_r1   <= vsync_in;
            h_ok_r1 <= (col < H_L);
        end
    end

    // Stage 2 lookup: a bar of height m lights rows ACTIVE_V-m .. ACTIVE_V-1
    always_comb begin
        mag_s    = bank_r[sel_r][bar_idx_s];
        thr_s    = V_L - ROW_W'(mag_s);
        in_bar_s = h_ok_r1 && (offset_s < LIT_W);
        lit_s    = in_bar_s && (row_r1 >= thr_s);
    end

`ifdef PEAK_HOLD_EN
    localparam logic [BAR_W-1:0] LAST_BAR = BAR_W'(NUM_BARS - 1);

    walk_state_t          walk_state_r, walk_state_s;
    logic [BAR_W-1:0]     walk_idx_r;
    logic [MAG_WIDTH-1:0] peak_r [0:NUM_BARS-1];
    logic [MAG_WIDTH-1:0] pk_s;
    logic [ROW_W-1:0]     pk_thr_s;
    logic                 mark_s;

    function automatic logic [MAG_WIDTH-1:0] peak_next(input logic [MAG_WIDTH-1:0] peak,
                                                       input logic [MAG_WIDTH-1:0] mag);
        logic [MAG_WIDTH-1:0] dec;
        if (peak == '0) begin
            dec = '0;
        end else begin
            dec = peak - MAG_WIDTH'(1);
        end
        if (dec > mag) begin
            return dec;
        end else begin
            return mag;
        end
    endfunction

    // Peak walk state register
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            walk_state_r <= WALK_IDLE;
        end else begin
            walk_state_r <= walk_state_s;
        end
    end

    // Peak walk next state: frame pulses arriving mid-walk are ignored
    always_comb begin
        walk_state_s = walk_state_r;
        case (walk_state_r)
            WALK_IDLE: begin
                if (frame_pulse) walk_state_s = WALK_RUN;
                else             walk_state_s = WALK_IDLE;
            end
            WALK_RUN: begin
                if (walk_idx_r == LAST_BAR) walk_state_s = WALK_IDLE;
                else                        walk_state_s = WALK_RUN;
            end
            default: walk_state_s = WALK_IDLE;
        endcase
    end

    // Walk datapath: starts the cycle after the pulse, so it sees the post-swap front bank
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                peak_r[i] <= '0;
            end
            walk_idx_r <= '0;
        end else if (walk_state_r == WALK_RUN) begin
            peak_r[walk_idx_r] <= peak_next(peak_r[walk_idx_r], bank_r[sel_r][walk_idx_r]);
            walk_idx_r         <= walk_idx_r + BAR_W'(1);
        end else begin
            walk_idx_r <= '0;
        end
    end

    // Two-row marker at the held peak height
    always_comb begin
        pk_s     = peak_r[bar_idx_s];
        pk_thr_s = V_L - ROW_W'(pk_s);
        mark_s   = (pk_s != '0) && in_bar_s &&
                   ((row_r1 == pk_thr_s) || (row_r1 == pk_thr_s + ROW_W'(1)));
    end
`endif

    // Pixel colour selection
    always_comb begin
        color_s = BG_COLOR;
`ifdef PEAK_HOLD_EN
        if (mark_s)     color_s = RGB_RED;
        else if (lit_s) color_s = BAR_COLOR;
        else            color_s = BG_COLOR;
`else
        if (lit_s) color_s = BAR_COLOR;
        else       color_s = BG_COLOR;
`endif
    end

    // Output registers; blanking forces black
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            rgb_out   <= 12'h000;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            de_out    <= 1'b0;
        end else begin
            rgb_out   <= de_r1 ? color_s : 12'h000;
            hsync_out <= hs_r1;
            vsync_out <= vs_r1;
            de_out    <= de_r1;
        end
    end
endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// Bench for spectrum_bar_renderer: directed and randomised line/frame stimulus checked
// against a divide/modulo reference model of the bar image and bank handshake.
module tb_spectrum_bar_renderer;
    localparam int NB  = 32;
    localparam int BW  = 20;
    localparam int GAP = 2;
    localparam int AV  = 480;
    localparam int AH  = 640;

    logic        clk = 1'b0;
    logic        resetn;
    logic [9:0]  row, col;
    logic        hsync_in, vsync_in, data_enable_in, frame_pulse;
    logic [11:0] rgb_out;
    logic        hsync_out, vsync_out, de_out;

    spectrum_bar_renderer_if bif ();

    spectrum_bar_renderer dut (
        .clk            (clk),
        .resetn         (resetn),
        .bin            (bif),
        .row            (row),
        .col            (col),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .data_enable_in (data_enable_in),
        .frame_pulse    (frame_pulse),
        .rgb_out        (rgb_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .de_out         (de_out)
    );

    always #20 clk = ~clk;

    int          bank_m [2][NB];
    int          peak_m [NB];
    int          sel_m;
    bit          busy_m;
    logic [14:0] exp_q [$];
    int          tag_q [$];
    int          n_cmp, n_bad;

    function automatic logic [11:0] pix_model(int r, int c, bit de);
        int b, o, m;
        bit inb;
        if (!de || c >= AH) return 12'h000;
        b   = c / BW;
        o   = c % BW;
        m   = bank_m[sel_m][b];
        inb = (o < BW - GAP);
`ifdef PEAK_HOLD_EN
        if (inb && peak_m[b] > 0 && (r == AV - peak_m[b] || r == AV - peak_m[b] + 1)) return 12'hF00;
`endif
        if (inb && r >= AV - m) return 12'h0F0;
        return 12'h000;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            bank_m[0][i] = 0;
            bank_m[1][i] = 0;
            peak_m[i]    = 0;
        end
        sel_m  = 0;
        busy_m = 1'b0;
        exp_q.delete();
        tag_q.delete();
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pixel clock: drive inputs, advance the model, check the output due now
    task automatic cyc(int r, int c, bit de, bit hs, bit vs, bit fp);
        logic [14:0] e;
        int a, t;
        row = 10'(r); col = 10'(c);
        data_enable_in = de; hsync_in = hs; vsync_in = vs; frame_pulse = fp;
        a = int'(bif.bin_wr_addr);
        if (bif.bin_wr_en && !busy_m && a < NB)
            bank_m[sel_m ^ 1][a] = (int'(bif.bin_wr_data) > AV) ? AV : int'(bif.bin_wr_data);
        if (fp && busy_m) begin
            sel_m  = sel_m ^ 1;
            busy_m = 1'b0;
        end else if (bif.bin_commit) begin
            busy_m = 1'b1;
        end
`ifdef PEAK_HOLD_EN
        if (fp) begin
            for (int i = 0; i < NB; i++) begin
                peak_m[i] = (peak_m[i] > 0) ? peak_m[i] - 1 : 0;
                if (bank_m[sel_m][i] > peak_m[i]) peak_m[i] = bank_m[sel_m][i];
            end
        end
`endif
        exp_q.push_back({pix_model(r, c, de), hs, vs, de});
        tag_q.push_back(r * 1000 + c);
        @(posedge clk);
        #1;
        chk("bin_busy", 32'(bif.bin_busy), 32'(busy_m));
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk($sformatf("pixel row %0d col %0d {rgb,hs,vs,de}", t / 1000, t % 1000),
                32'({rgb_out, hsync_out, vsync_out, de_out}), 32'(e));
        end
        bif.bin_wr_en  = 1'b0;
        bif.bin_commit = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(AV + 10, 700, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic blank(int n);
        for (int i = 0; i < n; i++)
            cyc(AV + 10, 700, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic line(int r);
        for (int c = 0; c < AH; c++) cyc(r, c, 1'b1, 1'b1, 1'b1, 1'b0);
        blank(6);
    endtask

    task automatic frame();
        cyc(AV, 700, 1'b0, 1'b1, 1'b0, 1'b1);
        blank(40);
    endtask

    task automatic wr(int a, int d);
        bif.bin_wr_en   = 1'b1;
        bif.bin_wr_addr = 5'(a);
        bif.bin_wr_data = 9'(d);
        idle(1);
    endtask

    task automatic commit();
        bif.bin_commit = 1'b1;
        idle(1);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, " rgb_out"},   32'(rgb_out),      32'h000);
        chk({tag, " hsync_out"}, 32'(hsync_out),    32'h1);
        chk({tag, " vsync_out"}, 32'(vsync_out),    32'h1);
        chk({tag, " de_out"},    32'(de_out),       32'h0);
        chk({tag, " bin_busy"},  32'(bif.bin_busy), 32'h0);
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        resetn = 1'b1;
        bif.bin_wr_en = 1'b0; bif.bin_wr_addr = '0; bif.bin_wr_data = '0; bif.bin_commit = 1'b0;
        row = '0; col = '0; data_enable_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; frame_pulse = 1'b0;
        model_clear();

        #5 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;
        idle(4);

        // Empty image after reset
        line(0); line(240); line(479);
        frame();

        // Full, half and single-row bars
        wr(0, 480); wr(1, 240); wr(31, 1);
        commit();
        frame();
        line(0); line(239); line(240); line(478); line(479);

        // Rewrite every bar, clamp oversize heights, then a write dropped while busy
        for (int i = 0; i < NB; i++) wr(i, $urandom_range(0, 511));
        wr(5, 500); wr(6, 511);
        commit();
        wr(0, 100);
        blank(3);
        frame();
        line(0); line(479); line($urandom_range(0, 479));

        // Commit coincident with a frame pulse swaps only on the next pulse
        for (int i = 0; i < NB; i++) wr(i, $urandom_range(0, 480));
        bif.bin_commit = 1'b1;
        cyc(AV, 700, 1'b0, 1'b1, 1'b0, 1'b1);
        blank(40);
        line($urandom_range(0, 479));
        frame();
        line($urandom_range(0, 479)); line(479);

        // Asynchronous reset in the middle of a visible line
        for (int c = 0; c < 300; c++) cyc(200, c, 1'b1, 1'b1, 1'b1, 1'b0);
        #5 resetn = 1'b0;
        #1;
        check_reset_outputs("midframe reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_clear();
        idle(4);
        line(479); line(100);
        for (int i = 0; i < NB; i++) wr(i, $urandom_range(0, 511));
        commit();
        frame();
        line($urandom_range(0, 479)); line(479);

        // Random partial updates, some committed and some not
        repeat (6) begin
            repeat ($urandom_range(1, 8)) wr($urandom_range(0, NB - 1), $urandom_range(0, 511));
            if ($urandom_range(0, 1) == 1) commit();
            frame();
            line($urandom_range(0, 479));
        end

`ifdef PEAK_HOLD_EN
        for (int i = 0; i < NB; i++) wr(i, (i == 2) ? 200 : 0);
        commit();
        frame();
        line(280); line(281);
        for (int i = 0; i < NB; i++) wr(i, 0);
        commit();
        frame();
        line(281); line(282);
        frame();
        line(282); line(283);
`endif

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
